prefetch_queue: RTL and testbench

PREFETCH_QUEUE -- requirements
Module: prefetch_queue

---
 rtl/prefetch_queue.sv | 82 ++++++++
 tb/tb_prefetch_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_queue.sv
// Fetch-side prefetch queue: buffers {pc, instr} pairs between imem and decode.
// Redirect beats flush; flush refetches from the current head PC.
module prefetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int         CW        = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    output logic [31:0]   imem_addr,
    input  logic [31:0]   imem_rdata,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    input  logic          stall_D,
    input  logic          flush_D,
    output logic [31:0]   instr_D,
    output logic [31:0]   pc_D,
    output logic          valid_D,
    output logic [CW-1:0] count
);

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [31:0]   fetch_pc;
    logic [31:0]   pc_mem  [DEPTH];
    logic [31:0]   ins_mem [DEPTH];
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count  = wr_ptr - rd_ptr;

    assign valid_D   = ~empty;
    assign instr_D   = empty ? NOP_INSTR : ins_mem[rd_idx];
    assign pc_D      = empty ? fetch_pc  : pc_mem[rd_idx];
    assign imem_addr = fetch_pc;

    assign pop  = valid_D & ~stall_D & ~redirect & ~flush_D;
    assign push = (~full | pop) & ~redirect & ~flush_D;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else if (flush_D) begin
            // pc_D equals fetch_pc when empty, so this covers both cases
            fetch_pc <= pc_D;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
                wr_ptr   <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible between the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_idx]  <= fetch_pc;
            ins_mem[wr_idx] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_prefetch_queue.sv
// Randomized bench for prefetch_queue against a queue-based reference model.
// Includes directed reset, stall-fill, redirect, flush and async-reset scenarios.
module tb_prefetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall_D;
    logic        flush_D;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic        valid_D;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] mq[$];
    logic [31:0] m_fpc;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_0013;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .stall_D(stall_D), .flush_D(flush_D),
        .instr_D(instr_D), .pc_D(pc_D), .valid_D(valid_D), .count(count)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fpc = RPC;
    endtask

    // One rising edge of the reference model, applied with current inputs
    task automatic model_edge();
        logic [31:0] head_pc;
        bit          do_pop;
        bit          do_push;
        if (!reset) begin
            model_reset();
        end else if (redirect) begin
            mq.delete();
            m_fpc = redirect_pc;
        end else if (flush_D) begin
            if (mq.size() > 0) begin
                head_pc = mq[0][63:32];
                m_fpc   = head_pc;
            end
            mq.delete();
        end else begin
            do_pop  = (mq.size() > 0) && !stall_D;
            do_push = (mq.size() < DEPTH) || do_pop;
            if (do_pop)
                void'(mq.pop_front());
            if (do_push) begin
                mq.push_back({m_fpc, mem_word(m_fpc)});
                m_fpc = m_fpc + 32'd4;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [63:0] h;
        check({tag, ".count"}, 32'(count), 32'(mq.size()));
        check({tag, ".valid"}, 32'(valid_D), 32'(mq.size() != 0));
        check({tag, ".addr"}, imem_addr, m_fpc);
        if (mq.size() > 0) begin
            h = mq[0];
            check({tag, ".pc"}, pc_D, h[63:32]);
            check({tag, ".instr"}, instr_D, h[31:0]);
        end else begin
            check({tag, ".pc"}, pc_D, m_fpc);
            check({tag, ".instr"}, instr_D, NOP);
        end
    endtask

    task automatic step(input string tag, input logic rd, input logic [31:0] rp,
                        input logic st, input logic fl);
        redirect    = rd;
        redirect_pc = rp;
        stall_D     = st;
        flush_D     = fl;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        model_reset();
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        stall_D     = 1'b0;
        flush_D     = 1'b0;
        model_reset();
        #3;
        do_reset();

        // streaming from reset: count 1 steady, pc 0,4,8,C
        for (int i = 0; i < 4; i++) begin
            step("stream", 1'b0, '0, 1'b0, 1'b0);
            check("stream.pc_abs", pc_D, 32'(i * 4));
        end
        check("stream.cnt_abs", 32'(count), 32'd1);

        do_reset();
        for (int i = 0; i < 6; i++)
            step("fill", 1'b0, '0, 1'b1, 1'b0);
        check("fill.cnt_abs", 32'(count), 32'd4);
        check("fill.addr_abs", imem_addr, 32'h10);
        check("fill.pc_abs", pc_D, 32'h0);

        for (int i = 0; i < 6; i++) begin
            step("drain", 1'b0, '0, 1'b0, 1'b0);
            check("drain.pc_abs", pc_D, 32'(4 * (i + 1)));
            check("drain.cnt_abs", 32'(count), 32'd4);
        end

        do_reset();
        step("pre_rd", 1'b0, '0, 1'b1, 1'b0);
        step("pre_rd", 1'b0, '0, 1'b1, 1'b0);
        step("pre_rd", 1'b0, '0, 1'b1, 1'b0);
        check("pre_rd.cnt_abs", 32'(count), 32'd3);
        step("redir", 1'b1, 32'h100, 1'b0, 1'b0);
        check("redir.addr_abs", imem_addr, 32'h100);
        check("redir.instr_abs", instr_D, 32'h13);
        step("redir2", 1'b0, '0, 1'b0, 1'b0);
        check("redir2.pc_abs", pc_D, 32'h100);

        do_reset();
        for (int i = 0; i < 4; i++)
            step("pre_fl", 1'b0, '0, 1'b1, 1'b0);
        step("pre_fl", 1'b0, '0, 1'b0, 1'b0);
        step("pre_fl", 1'b0, '0, 1'b0, 1'b0);
        check("pre_fl.pc_abs", pc_D, 32'h8);
        step("flush", 1'b0, '0, 1'b1, 1'b1);
        check("flush.addr_abs", imem_addr, 32'h8);
        step("flush2", 1'b0, '0, 1'b1, 1'b0);
        check("flush2.pc_abs", pc_D, 32'h8);
        step("flush_empty", 1'b0, '0, 1'b0, 1'b1);
        step("flush_empty", 1'b0, '0, 1'b0, 1'b1);

        step("both", 1'b1, 32'h200, 1'b0, 1'b1);
        check("both.addr_abs", imem_addr, 32'h200);
        step("both2", 1'b0, '0, 1'b1, 1'b0);
        step("both2", 1'b0, '0, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("midrst.cnt_abs", 32'(count), 32'd0);
        check("midrst.addr_abs", imem_addr, 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            logic        rd;
            logic        fl;
            logic        st;
            logic [31:0] rp;
            rd = ($urandom_range(0, 15) == 0);
            fl = ($urandom_range(0, 15) == 0);
            st = ($urandom_range(0, 2) == 0);
            rp = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            if ($urandom_range(0, 20) == 0)
                rp = 32'hFFFF_FFF8;
            if ($urandom_range(0, 299) == 0)
                do_reset();
            else
                step("rand", rd, rp, st, fl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
